ht_sig_tx_gen: RTL and testbench
================================

Name: ht_sig_tx_gen

Overview:
Transmit-side HT-SIG field generator for the openofdm_tx chain. It latches the HT-SIG parameters from the TX controller on a start pulse. It then serialises the 48-bit HT-SIG (HT-SIG1 24 bits, HT-SIG2 24 bits) one bit per valid/ready handshake to the convolutional encoder. The CRC-8 over bits 0..33 is computed on the fly, using the same polynomial and conventions the RX-side HT-SIG CRC checker expects.

Parameters:
CRC_INIT, 8'hff, CRC register value loaded at each start.
TAIL_BITS, 6, number of zero tail bits appended after the CRC; fixed at 6 for 802.11n.

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  global clock-enable; when low, no state changes and no handshake completes
start  in  1  one-cycle request; honoured only in IDLE
mcs  in  7  HT MCS index
cbw40  in  1  channel bandwidth: 1 = 40 MHz
ht_length  in  16  PSDU length in bytes
smoothing  in  1  smoothing bit
not_sounding  in  1  not-sounding bit
aggregation  in  1  A-MPDU bit
stbc  in  2  STBC field
fec_ldpc  in  1  FEC coding: 1 = LDPC
short_gi  in  1  short guard interval
ness  in  2  number of extension spatial streams
bit_out  out  1  current serial bit
bit_valid  out  1  bit_out is valid
bit_ready  in  1  downstream accepts bit_out
busy  out  1  high from start acceptance until the last bit is accepted
done  out  1  one-cycle pulse after the final (48th) bit is accepted
crc_out  out  8  final CRC as transmitted, first-sent bit in [0]; valid once the CRC phase begins, held until the next start

Behaviour:
- Reset values: bit_out=0, bit_valid=0, busy=0, done=0, crc_out=0. State=IDLE, bit counter=0, CRC register=CRC_INIT.
- Handshake: a bit transfers in a cycle where enable & bit_valid & bit_ready are all high.
  - bit_out and bit_valid are registered.
  - bit_out holds stable while bit_valid & !bit_ready.
- Field layout, transmit order, bits 0..47:
  - 0-6: mcs LSB first
  - 7: cbw40
  - 8-23: ht_length LSB first
  - 24: smoothing
  - 25: not_sounding
  - 26: reserved, forced 1
  - 27: aggregation
  - 28-29: stbc LSB first
  - 30: fec_ldpc
  - 31: short_gi
  - 32-33: ness LSB first
  - 34-41: CRC
  - 42-47: zeros
- States: IDLE -> DATA -> CRC -> TAIL -> IDLE.
  - IDLE: when enable & start, latch all field inputs into a 34-bit shadow, load the CRC register with CRC_INIT, counter=0, busy=1. The next cycle bit_valid=1 with bit 0. Latency from start to first valid bit is 1 cycle.
  - DATA, counter 0..33: on each transfer of bit b, the CRC register C updates as:
    - C0<=b^C7
    - C1<=b^C7^C0
    - C2<=b^C7^C1
    - C[7:3]<=C[6:2]
  - The transfer of bit 33 moves the block to CRC. crc_out[i] is captured as ~C[7-i] from the register value after bit 33's update.
  - CRC, counter 34..41: bit_out = crc_out[counter-34], i.e. ~C7 first, ~C0 last. The CRC register does not update during this phase.
  - TAIL, counter 42..47: bit_out=0.
  - The transfer of bit 47 clears bit_valid and busy, returns to IDLE and pulses done for one cycle.
- Back-to-back: a start in the cycle done is high is accepted, so the next frame's bit 0 is valid on the following cycle.
- start while busy: ignored; latched fields are unchanged.
- enable low: everything is frozen, including bit_valid; no transfer counts even if bit_ready is high.
- Asynchronous reset mid-frame: immediate return to reset values. No done pulse is issued.
- Counter: 6-bit, range 0..47. Counts only on transfers and never wraps past 47.

Decomposition:
- Shared tx package holds:
  - HT-SIG bit-offset constants (MCS_LSB=0, CBW=7, LEN_LSB=8, RSVD=26, CRC_LSB=34, TAIL_LSB=42, HT_SIG_BITS=48)
  - the state enum
  - CRC_INIT
- One sub-module: ht_sig_crc8_gen. It is the serial CRC register with clear, update-strobe and complemented, bit-reversed output, and is reused by the L-SIG/SERVICE logic if needed.

Test Plan:
- Reset, then start with mcs=7, cbw40=0, ht_length=16'h1234, other fields 0, bit_ready=1 -> bits 0-6 = 1,1,1,0,0,0,0; bit 7=0; bits 8-23 = 0x1234 LSB first; bit 26=1; bits 42-47=0; done 49 cycles after start.
- Same 34 bits fed into the RX HT-SIG CRC checker model -> its crc output equals transmitted bits 34..41 and crc_out. Repeat for 200 random field sets.
- bit_ready toggled pseudo-randomly at 50% -> bit_out stable while stalled; exactly 48 transfers; bit stream identical to the bit_ready=1 run.
- start pulsed at counter 10 mid-frame -> ignored; output frame unchanged. Start in the same cycle as done -> second frame's bit 0 valid next cycle.
- enable held low for 5 cycles at counter 20 with bit_ready=1 -> counter stays 20, bit_out unchanged; the frame completes 5 cycles later.
- reset asserted at counter 37 -> bit_valid, busy and done go to 0 immediately, with no done pulse. A new start produces a correct full frame.

Source files
------------

// File: rtl/ht_sig_tx_pkg.sv
// Shared definitions for the HT-SIG transmit path: field offsets, FSM states,
// CRC seed and the 34-bit HT-SIG payload packer.
package ht_sig_tx_pkg;

  localparam int unsigned MCS_LSB     = 0;
  localparam int unsigned CBW         = 7;
  localparam int unsigned LEN_LSB     = 8;
  localparam int unsigned RSVD        = 26;
  localparam int unsigned CRC_LSB     = 34;
  localparam int unsigned TAIL_LSB    = 42;
  localparam int unsigned HT_SIG_BITS = 48;

  localparam logic [7:0] HT_CRC_INIT = 8'hff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_TAIL
  } ht_sig_state_e;

  // Bit i of the result is transmitted i-th; bit RSVD is always 1.
  function automatic logic [CRC_LSB-1:0] ht_sig_pack(
    input logic [6:0]  mcs,
    input logic        cbw40,
    input logic [15:0] ht_length,
    input logic        smoothing,
    input logic        not_sounding,
    input logic        aggregation,
    input logic [1:0]  stbc,
    input logic        fec_ldpc,
    input logic        short_gi,
    input logic [1:0]  ness
  );
    return {ness, short_gi, fec_ldpc, stbc, aggregation, 1'b1,
            not_sounding, smoothing, ht_length, cbw40, mcs};
  endfunction

endpackage

// File: rtl/ht_sig_crc8_gen.sv
// Serial CRC-8 (x^8+x^2+x+1) register with clear and update strobe; the
// output is the complemented, bit-reversed post-update value.
module ht_sig_crc8_gen #(
  parameter logic [7:0] INIT = 8'hff
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       upd,
  input  logic       din,
  output logic [7:0] crc_final
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] crc_nxt;

  always_comb begin
    crc_nxt = {crc_q[6:2],
               din ^ crc_q[7] ^ crc_q[1],
               din ^ crc_q[7] ^ crc_q[0],
               din ^ crc_q[7]};
    crc_d = crc_q;
    if (clr) begin
      crc_d = INIT;
    end else if (upd) begin
      crc_d = crc_nxt;
    end
    // crc_final[0] is ~C7 and is sent first
    crc_final = ~{crc_nxt[0], crc_nxt[1], crc_nxt[2], crc_nxt[3],
                  crc_nxt[4], crc_nxt[5], crc_nxt[6], crc_nxt[7]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/ht_sig_tx_gen.sv
// HT-SIG transmit generator: latches fields on start and serialises the
// 48-bit HT-SIG (data, CRC-8, tail) one bit per valid/ready handshake.
module ht_sig_tx_gen
  import ht_sig_tx_pkg::*;
#(
  parameter logic [7:0]  CRC_INIT  = HT_CRC_INIT,
  parameter int unsigned TAIL_BITS = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [6:0]  mcs,
  input  logic        cbw40,
  input  logic [15:0] ht_length,
  input  logic        smoothing,
  input  logic        not_sounding,
  input  logic        aggregation,
  input  logic [1:0]  stbc,
  input  logic        fec_ldpc,
  input  logic        short_gi,
  input  logic [1:0]  ness,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  crc_out
);

  localparam logic [5:0] LAST_IDX      = 6'(TAIL_LSB + TAIL_BITS - 1);
  localparam logic [5:0] LAST_DATA_IDX = 6'(CRC_LSB - 1);

  ht_sig_state_e state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [33:0]   shadow_q, shadow_d;
  logic          bit_out_q, bit_out_d;
  logic          bit_valid_q, bit_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    crc_out_q, crc_out_d;

  logic          xfer;
  logic          crc_clr;
  logic          crc_upd;
  logic [2:0]    crc_idx;
  logic [7:0]    crc_final;

  ht_sig_crc8_gen #(
    .INIT(CRC_INIT)
  ) u_crc (
    .clk      (clock),
    .rst      (reset),
    .clr      (crc_clr),
    .upd      (crc_upd),
    .din      (bit_out_q),
    .crc_final(crc_final)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    crc_out_d   = crc_out_q;
    crc_clr     = 1'b0;
    crc_upd     = 1'b0;
    crc_idx     = '0;
    xfer        = enable & bit_valid_q & bit_ready;

    if (enable) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shadow_d    = ht_sig_pack(mcs, cbw40, ht_length, smoothing,
                                      not_sounding, aggregation, stbc,
                                      fec_ldpc, short_gi, ness);
            cnt_d       = '0;
            crc_clr     = 1'b1;
            busy_d      = 1'b1;
            bit_valid_d = 1'b1;
            bit_out_d   = shadow_d[0];
            state_d     = ST_DATA;
          end
        end
        ST_DATA, ST_CRC, ST_TAIL: begin
          if (xfer) begin
            if (cnt_q == LAST_IDX) begin
              cnt_d       = '0;
              bit_out_d   = 1'b0;
              bit_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              cnt_d   = cnt_q + 6'd1;
              crc_upd = (state_q == ST_DATA);
              // bit 34 is registered on the same edge as bit 33's CRC update,
              // so it is taken from the freshly captured value
              if (cnt_q == LAST_DATA_IDX) begin
                crc_out_d = crc_final;
              end
              if (cnt_d < 6'(CRC_LSB)) begin
                state_d   = ST_DATA;
                bit_out_d = shadow_q[cnt_d];
              end else if (cnt_d < 6'(TAIL_LSB)) begin
                state_d   = ST_CRC;
                crc_idx   = 3'(cnt_d - 6'(CRC_LSB));
                bit_out_d = crc_out_d[crc_idx];
              end else begin
                state_d   = ST_TAIL;
                bit_out_d = 1'b0;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      crc_out_q   <= crc_out_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign crc_out   = crc_out_q;

endmodule

// File: tb/tb_ht_sig_tx_gen.sv
// Directed self-checking bench for ht_sig_tx_gen with an independent
// HT-SIG packer and RX-style CRC-8 checker model.
module tb_ht_sig_tx_gen;

  typedef struct packed {
    logic [6:0]  mcs;
    logic        cbw40;
    logic [15:0] len;
    logic        smoothing;
    logic        not_sounding;
    logic        aggregation;
    logic [1:0]  stbc;
    logic        fec_ldpc;
    logic        short_gi;
    logic [1:0]  ness;
  } field_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [6:0]  mcs;
  logic        cbw40;
  logic [15:0] ht_length;
  logic        smoothing;
  logic        not_sounding;
  logic        aggregation;
  logic [1:0]  stbc;
  logic        fec_ldpc;
  logic        short_gi;
  logic [1:0]  ness;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        done;
  logic [7:0]  crc_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ht_sig_tx_gen dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .mcs         (mcs),
    .cbw40       (cbw40),
    .ht_length   (ht_length),
    .smoothing   (smoothing),
    .not_sounding(not_sounding),
    .aggregation (aggregation),
    .stbc        (stbc),
    .fec_ldpc    (fec_ldpc),
    .short_gi    (short_gi),
    .ness        (ness),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .busy        (busy),
    .done        (done),
    .crc_out     (crc_out)
  );

  function automatic logic [33:0] pack_f(input field_t f);
    logic [33:0] v;
    v        = '0;
    v[6:0]   = f.mcs;
    v[7]     = f.cbw40;
    v[23:8]  = f.len;
    v[24]    = f.smoothing;
    v[25]    = f.not_sounding;
    v[26]    = 1'b1;
    v[27]    = f.aggregation;
    v[29:28] = f.stbc;
    v[30]    = f.fec_ldpc;
    v[31]    = f.short_gi;
    v[33:32] = f.ness;
    return v;
  endfunction

  // RX-side checker: shift left, xor 0x07 on feedback, complement and reverse.
  function automatic logic [7:0] rx_crc(input logic [33:0] d);
    logic [7:0] c;
    logic [7:0] o;
    logic       fb;
    c = 8'hff;
    for (int i = 0; i < 34; i++) begin
      fb = d[i] ^ c[7];
      c  = {c[6:0], 1'b0} ^ {5'b0, fb, fb, fb};
    end
    for (int i = 0; i < 8; i++) o[i] = ~c[7-i];
    return o;
  endfunction

  function automatic logic [47:0] exp_frame(input field_t f);
    logic [33:0] d;
    d = pack_f(f);
    return {6'b0, rx_crc(d), d};
  endfunction

  function automatic field_t rand_fields();
    field_t f;
    f.mcs          = 7'($urandom);
    f.cbw40        = 1'($urandom);
    f.len          = 16'($urandom);
    f.smoothing    = 1'($urandom);
    f.not_sounding = 1'($urandom);
    f.aggregation  = 1'($urandom);
    f.stbc         = 2'($urandom);
    f.fec_ldpc     = 1'($urandom);
    f.short_gi     = 1'($urandom);
    f.ness         = 2'($urandom);
    return f;
  endfunction

  task automatic apply(input field_t f);
    mcs          = f.mcs;
    cbw40        = f.cbw40;
    ht_length    = f.len;
    smoothing    = f.smoothing;
    not_sounding = f.not_sounding;
    aggregation  = f.aggregation;
    stbc         = f.stbc;
    fec_ldpc     = f.fec_ldpc;
    short_gi     = f.short_gi;
    ness         = f.ness;
  endtask

  task automatic start_frame(input field_t f);
    apply(f);
    enable    = 1'b1;
    start     = 1'b1;
    bit_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Collects transferred bits; cyc counts edges since the start-sampling edge.
  task automatic collect(input int mode, input int start_at, input field_t alt,
                         input int en_low_at, input int abort_at,
                         input bit chain, input field_t nxt,
                         output logic [47:0] bits, output int nx,
                         output int cyc, output int err, output bit gd);
    logic pv_stall;
    logic pbo;
    int   en_left;
    bit   st_done;
    bit   en_done;
    bits = '0; nx = 0; cyc = 1; err = 0; gd = 1'b0;
    pv_stall = 1'b0; pbo = 1'b0; en_left = 0; st_done = 1'b0; en_done = 1'b0;
    while (cyc < 400) begin
      if (pv_stall && (bit_out !== pbo || bit_valid !== 1'b1)) err++;
      if (done === 1'b1) begin
        gd = 1'b1;
        if (chain) begin
          apply(nxt);
          enable = 1'b1; bit_ready = 1'b1; start = 1'b1;
          @(posedge clock); #1;
          start = 1'b0;
        end
        break;
      end
      if (abort_at >= 0 && nx == abort_at) break;
      start = 1'b0;
      if (start_at >= 0 && nx == start_at && !st_done) begin
        apply(alt); start = 1'b1; st_done = 1'b1;
      end
      if (en_low_at >= 0 && nx == en_low_at && !en_done) begin
        en_left = 5; en_done = 1'b1;
      end
      enable = (en_left == 0);
      if (en_left > 0) en_left--;
      bit_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (enable && bit_valid === 1'b1 && bit_ready) begin
        if (nx < 48) bits[nx] = bit_out; else err++;
        nx++;
      end
      pv_stall = (bit_valid === 1'b1) && !(enable && bit_ready);
      pbo = bit_out;
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
    end
  endtask

  field_t none_f = '0;

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; bit_ready = 1'b0;
    apply(none_f);
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bit_out !== 1'b0) begin failures++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (crc_out !== 8'h00) begin failures++; $display("FAIL reset_crc_out got=%h exp=00", crc_out); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL idle_bit_valid got=%b exp=0", bit_valid); end
  endtask

  task automatic test_basic();
    field_t f;
    logic [47:0] bits, ef;
    int nx, cyc, err;
    bit gd;
    f = '0; f.mcs = 7'd7; f.len = 16'h1234;
    ef = exp_frame(f);
    start_frame(f);
    checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b%b exp=11", bit_valid, bit_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    collect(0, -1, none_f, -1, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (bits[6:0] !== 7'b0000111) begin failures++; $display("FAIL basic_mcs got=%b exp=0000111", bits[6:0]); end
    checks++; if (bits[7] !== 1'b0) begin failures++; $display("FAIL basic_cbw got=%b exp=0", bits[7]); end
    checks++; if (bits[23:8] !== 16'h1234) begin failures++; $display("FAIL basic_len got=%h exp=1234", bits[23:8]); end
    checks++; if (bits[26] !== 1'b1) begin failures++; $display("FAIL basic_rsvd got=%b exp=1", bits[26]); end
    checks++; if (bits[47:42] !== 6'b0) begin failures++; $display("FAIL basic_tail got=%b exp=000000", bits[47:42]); end
    checks++; if (bits !== ef) begin failures++; $display("FAIL basic_frame got=%h exp=%h", bits, ef); end
    checks++; if (crc_out !== ef[41:34]) begin failures++; $display("FAIL basic_crc_out got=%h exp=%h", crc_out, ef[41:34]); end
    checks++; if (nx !== 48) begin failures++; $display("FAIL basic_xfers got=%0d exp=48", nx); end
    checks++; if (!gd || cyc !== 49) begin failures++; $display("FAIL basic_done_latency got=%0d done=%b exp=49", cyc, gd); end
    checks++; if (busy !== 1'b0 || bit_valid !== 1'b0) begin failures++; $display("FAIL basic_end_idle got busy=%b valid=%b exp=0 0", busy, bit_valid); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_crc_random();
    field_t f;
    logic [47:0] bits, ef;
    int nx, cyc, err;
    bit gd;
    for (int n = 0; n < 200; n++) begin
      f  = rand_fields();
      ef = exp_frame(f);
      start_frame(f);
      collect(0, -1, none_f, -1, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
      checks++; if (bits !== ef || !gd) begin failures++; $display("FAIL rand_frame n=%0d got=%h exp=%h done=%b", n, bits, ef, gd); end
      checks++; if (crc_out !== ef[41:34]) begin failures++; $display("FAIL rand_crc_out n=%0d got=%h exp=%h", n, crc_out, ef[41:34]); end
    end
  endtask

  task automatic test_stall();
    field_t f;
    logic [47:0] bits, ef;
    int nx, cyc, err;
    bit gd;
    f = '0; f.mcs = 7'd5; f.len = 16'hA5C3; f.stbc = 2'd2; f.ness = 2'd1; f.short_gi = 1'b1;
    ef = exp_frame(f);
    start_frame(f);
    collect(1, -1, none_f, -1, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (bits !== ef) begin failures++; $display("FAIL stall_frame got=%h exp=%h", bits, ef); end
    checks++; if (nx !== 48 || !gd) begin failures++; $display("FAIL stall_xfers got=%0d done=%b exp=48", nx, gd); end
    checks++; if (err !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", err); end
  endtask

  task automatic test_start_ignored();
    field_t f, alt;
    logic [47:0] bits, ef;
    int nx, cyc, err;
    bit gd;
    f = '0; f.mcs = 7'd33; f.len = 16'h0F0F; f.aggregation = 1'b1; f.fec_ldpc = 1'b1;
    alt = '1;
    ef = exp_frame(f);
    start_frame(f);
    collect(0, 10, alt, -1, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (bits !== ef) begin failures++; $display("FAIL busy_start_frame got=%h exp=%h", bits, ef); end
    checks++; if (!gd || cyc !== 49) begin failures++; $display("FAIL busy_start_latency got=%0d exp=49", cyc); end
  endtask

  task automatic test_enable();
    field_t f;
    logic [47:0] bits, ef;
    int nx, cyc, err;
    bit gd;
    f = '0; f.mcs = 7'd76; f.cbw40 = 1'b1; f.len = 16'hFFFF; f.smoothing = 1'b1;
    ef = exp_frame(f);
    start_frame(f);
    collect(0, -1, none_f, 20, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (bits !== ef) begin failures++; $display("FAIL enable_frame got=%h exp=%h", bits, ef); end
    checks++; if (!gd || cyc !== 54) begin failures++; $display("FAIL enable_latency got=%0d exp=54", cyc); end
    checks++; if (err !== 0) begin failures++; $display("FAIL enable_frozen got=%0d exp=0", err); end
  endtask

  task automatic test_back_to_back();
    field_t fa, fb;
    logic [47:0] bits, ea, eb;
    int nx, cyc, err;
    bit gd;
    fa = '0; fa.mcs = 7'd1; fa.len = 16'h0001;
    fb = '0; fb.mcs = 7'd2; fb.len = 16'h8000; fb.not_sounding = 1'b1;
    ea = exp_frame(fa);
    eb = exp_frame(fb);
    start_frame(fa);
    collect(0, -1, none_f, -1, -1, 1'b1, fb, bits, nx, cyc, err, gd);
    checks++; if (bits !== ea || !gd) begin failures++; $display("FAIL b2b_frame_a got=%h exp=%h", bits, ea); end
    checks++; if (bit_valid !== 1'b1 || busy !== 1'b1 || bit_out !== eb[0]) begin
      failures++; $display("FAIL b2b_first_bit got valid=%b busy=%b bit=%b exp=1 1 %b", bit_valid, busy, bit_out, eb[0]);
    end
    collect(0, -1, none_f, -1, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (bits !== eb) begin failures++; $display("FAIL b2b_frame_b got=%h exp=%h", bits, eb); end
    checks++; if (!gd || cyc !== 49) begin failures++; $display("FAIL b2b_latency got=%0d exp=49", cyc); end
  endtask

  task automatic test_reset_mid();
    field_t f;
    logic [47:0] bits, ef;
    int nx, cyc, err, dseen;
    bit gd;
    f = '0; f.mcs = 7'd9; f.len = 16'h4321; f.stbc = 2'd3;
    start_frame(f);
    collect(0, -1, none_f, -1, 37, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (nx !== 37) begin failures++; $display("FAIL rstmid_reach got=%0d exp=37", nx); end
    reset = 1'b1;
    #1;
    checks++; if (bit_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got valid=%b busy=%b done=%b exp=0 0 0", bit_valid, busy, done);
    end
    checks++; if (crc_out !== 8'h00) begin failures++; $display("FAIL rstmid_crc_out got=%h exp=00", crc_out); end
    dseen = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done !== 1'b0) dseen++;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    if (done !== 1'b0) dseen++;
    checks++; if (dseen !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dseen); end
    f.ness = 2'd2;
    ef = exp_frame(f);
    start_frame(f);
    collect(0, -1, none_f, -1, -1, 1'b0, none_f, bits, nx, cyc, err, gd);
    checks++; if (bits !== ef || !gd) begin failures++; $display("FAIL rstmid_new_frame got=%h exp=%h", bits, ef); end
    checks++; if (crc_out !== ef[41:34]) begin failures++; $display("FAIL rstmid_crc got=%h exp=%h", crc_out, ef[41:34]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_random();
    test_stall();
    test_start_ignored();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
